div_iter: RTL and testbench
===========================

Name: div_iter

Overview:
- Parameterised iterative integer divider, successor to the fixed 24-bit `div`.
- Radix-2 restoring algorithm, one quotient bit per clock.
- Handles signed and unsigned operands, annul, divide-by-zero and signed overflow, with a status flag for each.
- Sits beside the ALU in the EX stage; the EX stage stalls on busy_o until ready_o pulses.

Parameters:
- WIDTH, 24, operand, quotient and remainder width in bits (legal range 4..64).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- signed_div_i  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start_i.
- opdata1_i  in  WIDTH  dividend; sampled with start_i.
- opdata2_i  in  WIDTH  divisor; sampled with start_i.
- start_i  in  1  request a division; accepted only in IDLE.
- annul_i  in  1  abort the operation in progress.
- quotient_o  out  WIDTH  quotient of the last completed operation.
- remainder_o  out  WIDTH  remainder of the last completed operation.
- ready_o  out  1  one-cycle pulse: results valid and updated.
- busy_o  out  1  high in CALC and DONE.
- div_zero_o  out  1  last result was a divide by zero.
- overflow_o  out  1  last result was signed MIN / -1.

Behaviour:
- Reset, clk/rst: synchronous and active-high.
  - Forces IDLE and sets every output to 0.
  - Reset applied mid-operation abandons the operation; no ready_o pulse is produced.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - Outputs hold their last values.
  - Edge N with start_i=1 and annul_i=0 captures the operands.
  - annul_i has priority over start_i on the same edge; the start is dropped.
- Divisor zero at edge N:
  - quotient_o is all ones; remainder_o equals opdata1_i unmodified.
  - div_zero_o=1, overflow_o=0, ready_o<=1, next state DONE.
- Divisor non-zero at edge N:
  - Register |dividend| and |divisor| (magnitude only when signed_div_i=1).
  - Register the quotient sign (sign1 XOR sign2) and the remainder sign (sign1).
  - Clear the partial remainder, set the step counter to 0, next state CALC.
- CALC:
  - Each edge shifts the partial remainder left by 1 and brings in the next dividend MSB.
  - If the partial remainder is >= the divisor, subtract it and set the quotient bit.
  - Widths: partial remainder WIDTH+1 bits; |MIN| = 2^(WIDTH-1) fits unsigned in WIDTH bits.
  - The counter increments once per edge.
- Final step at edge N+WIDTH:
  - Negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set.
  - Register the results to the outputs and set ready_o<=1.
  - overflow_o=1 iff signed and dividend=MIN and divisor=-1; the result is then q=MIN, r=0. div_zero_o=0.
  - Next state DONE.
- Latency: ready_o is high in the cycle after edge N+WIDTH for a normal division, and in the cycle after edge N for divide by zero.
- DONE: lasts one cycle; ready_o<=0, next state IDLE. start_i is ignored in DONE.
- start_i in CALC or DONE is ignored and not queued.
- annul_i in CALC:
  - Next edge goes to IDLE; ready_o stays 0.
  - quotient_o, remainder_o and the flags keep their previous values.
- annul_i in DONE has no effect; the pulse is already committed.
- Operands may change after edge N without affecting the result.
- Truncating division: |r| < |divisor|, dividend = q*divisor + r.

Decomposition:
- Package div_pkg:
  - state typedef div_state_e {IDLE, CALC, DONE};
  - localparam for the counter width, $clog2(WIDTH+1).
- Sub-module div_step: combinational single restoring step.
  - Parameter WIDTH.
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: next partial remainder, quotient bit.

Test Plan:
- Unsigned 704/36, WIDTH=24 -> q=19, r=20; ready_o high exactly 24 edges after start, busy_o high throughout; flags 0.
- Signed -704/36 (0xFFFD40/0x000024) -> q=0xFFFFED (-19), r=0xFFFFEC (-20); signed 704/-36 -> q=-19, r=+20.
- Divide by zero: 1234/0 unsigned -> ready_o the cycle after start, q=0xFFFFFF, r=1234, div_zero_o=1.
- Signed overflow 0x800000/0xFFFFFF -> q=0x800000, r=0, overflow_o=1. The same operands unsigned -> q=0, r=0x800000, overflow_o=0.
- Annul at step 10 of 704/36 -> no ready_o pulse, busy_o drops next edge, outputs keep prior result. A following start 100/7 -> q=14, r=2.
- WIDTH=8 instance: unsigned 200/7 -> q=28, r=4, ready_o after 8 edges. start_i held high during CALC is ignored. rst asserted mid-CALC -> all outputs 0, IDLE.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg -- shared types and sizing helpers for the iterative divider.
//   div_state_e    : controller states (IDLE, CALC, DONE)
//   DIV_CNT_W      : step-counter width for the default 24-bit divider
//   div_cnt_width(): step-counter width for any WIDTH, $clog2(WIDTH+1)
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int DIV_WIDTH_DEFAULT = 24;
  localparam int DIV_CNT_W         = $clog2(DIV_WIDTH_DEFAULT + 1);

  function automatic int div_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// div_step -- one combinational radix-2 restoring division step.
//   rem_i     : partial remainder entering the step (WIDTH+1 bits)
//   bit_i     : next dividend bit shifted into the remainder
//   divisor_i : divisor magnitude
//   rem_o     : partial remainder leaving the step
//   q_o       : quotient bit produced by this step
module div_step #(
  parameter int WIDTH = 24
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_o
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  // One extra bit of headroom so the sign of the trial subtraction is exact.
  assign shifted = {rem_i, bit_i};
  assign trial   = shifted - {2'b00, divisor_i};
  assign q_o     = ~trial[WIDTH+1];
  assign rem_o   = q_o ? trial[WIDTH:0] : shifted[WIDTH:0];

endmodule

// File: rtl/div_iter.sv
// div_iter -- iterative signed/unsigned integer divider, one quotient bit per clock.
//   clk, rst       : clock, synchronous active-high reset
//   signed_div_i   : 1 = two's-complement operands
//   opdata1_i/2_i  : dividend / divisor, sampled with start_i in IDLE
//   start_i        : request a division (IDLE only)
//   annul_i        : abort a division in progress
//   quotient_o     : quotient of the last completed operation
//   remainder_o    : remainder of the last completed operation
//   ready_o        : one-cycle pulse when results update
//   busy_o         : high while in CALC or DONE
//   div_zero_o     : last result was a divide by zero
//   overflow_o     : last result was signed MIN / -1
module div_iter
  import div_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             signed_div_i,
  input  logic [WIDTH-1:0] opdata1_i,
  input  logic [WIDTH-1:0] opdata2_i,
  input  logic             start_i,
  input  logic             annul_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             ready_o,
  output logic             busy_o,
  output logic             div_zero_o,
  output logic             overflow_o
);

  localparam int CntW = div_cnt_width(WIDTH);

  div_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             ovf_q, ovf_d;   // overflow case detected at capture
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             ready_q, ready_d;
  logic             dz_q, dz_d;
  logic             ov_q, ov_d;

  logic [WIDTH:0]   step_rem;
  logic             step_q;
  logic             sign1, sign2;
  logic [WIDTH-1:0] q_fin, r_fin;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .bit_i     (dvd_q[WIDTH-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  assign sign1 = signed_div_i & opdata1_i[WIDTH-1];
  assign sign2 = signed_div_i & opdata2_i[WIDTH-1];
  assign q_fin = {dvd_q[WIDTH-2:0], step_q};
  assign r_fin = step_rem[WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    ovf_d   = ovf_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    ready_d = 1'b0;
    dz_d    = dz_q;
    ov_d    = ov_q;

    unique case (state_q)
      IDLE: begin
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            quot_d  = '1;
            remo_d  = opdata1_i;
            dz_d    = 1'b1;
            ov_d    = 1'b0;
            ready_d = 1'b1;
            state_d = DONE;
          end else begin
            // Negating MIN yields 2^(WIDTH-1), which is the correct unsigned magnitude.
            dvd_d   = sign1 ? -opdata1_i : opdata1_i;
            dvs_d   = sign2 ? -opdata2_i : opdata2_i;
            q_neg_d = sign1 ^ sign2;
            r_neg_d = sign1;
            ovf_d   = signed_div_i && (opdata1_i == {1'b1, {(WIDTH-1){1'b0}}})
                      && (opdata2_i == '1);
            rem_d   = '0;
            cnt_d   = '0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (annul_i) begin
          state_d = IDLE;
        end else begin
          rem_d = step_rem;
          dvd_d = q_fin;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(WIDTH - 1)) begin
            // MIN / -1 naturally produces q = MIN, r = 0; only the flag is extra.
            quot_d  = q_neg_q ? -q_fin : q_fin;
            remo_d  = r_neg_q ? -r_fin : r_fin;
            ov_d    = ovf_q;
            dz_d    = 1'b0;
            ready_d = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      ovf_q   <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
      ready_q <= 1'b0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      ovf_q   <= ovf_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      ready_q <= ready_d;
      dz_q    <= dz_d;
      ov_q    <= ov_d;
    end
  end

  assign quotient_o  = quot_q;
  assign remainder_o = remo_q;
  assign ready_o     = ready_q;
  assign busy_o      = (state_q != IDLE);
  assign div_zero_o  = dz_q;
  assign overflow_o  = ov_q;

endmodule

// File: tb/tb_div_iter.sv
module tb_div_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 24-bit instance
  logic        rst;
  logic        s24, st24, an24;
  logic [23:0] a24, b24, q24, r24;
  logic        rdy24, bsy24, dz24, ov24;

  // 8-bit instance
  logic        rst8;
  logic        s8, st8, an8;
  logic [7:0]  a8, b8, q8, r8;
  logic        rdy8, bsy8, dz8, ov8;

  int total  = 0;
  int passed = 0;

  div_iter #(.WIDTH(24)) dut24 (
    .clk(clk), .rst(rst), .signed_div_i(s24), .opdata1_i(a24), .opdata2_i(b24),
    .start_i(st24), .annul_i(an24), .quotient_o(q24), .remainder_o(r24),
    .ready_o(rdy24), .busy_o(bsy24), .div_zero_o(dz24), .overflow_o(ov24)
  );

  div_iter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .signed_div_i(s8), .opdata1_i(a8), .opdata2_i(b8),
    .start_i(st8), .annul_i(an8), .quotient_o(q8), .remainder_o(r8),
    .ready_o(rdy8), .busy_o(bsy8), .div_zero_o(dz8), .overflow_o(ov8)
  );

  // Drives one 24-bit operation and reports latency (edges after the start edge
  // until ready_o is seen) and whether busy_o stayed high throughout.
  task automatic launch24(input logic s, input logic [23:0] a, input logic [23:0] b,
                          output int lat, output bit busy_ok);
    @(posedge clk); #1;
    s24 = s; a24 = a; b24 = b; st24 = 1'b1;
    @(posedge clk); #1;
    st24 = 1'b0; a24 = 24'h5A5A5A; b24 = 24'h000003; s24 = ~s;
    lat = 0;
    busy_ok = bsy24;
    while (!rdy24 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (!bsy24) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rst8 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({q24, r24, rdy24, bsy24, dz24, ov24} !== 52'd0)
      $display("FAIL reset24: got q=%h r=%h rdy=%b bsy=%b dz=%b ov=%b want all 0", q24, r24, rdy24, bsy24, dz24, ov24);
    else passed++;
    total++;
    if ({q8, r8, rdy8, bsy8, dz8, ov8} !== 20'd0)
      $display("FAIL reset8: got q=%h r=%h rdy=%b bsy=%b dz=%b ov=%b want all 0", q8, r8, rdy8, bsy8, dz8, ov8);
    else passed++;
    rst = 1'b0; rst8 = 1'b0;
  endtask

  task automatic test_unsigned();
    int lat; bit bok;
    launch24(1'b0, 24'd704, 24'd36, lat, bok);
    total++;
    if (lat !== 24) $display("FAIL unsigned_latency: got %0d want 24", lat); else passed++;
    total++;
    if (!bok) $display("FAIL unsigned_busy: got busy low during op want high"); else passed++;
    total++;
    if (q24 !== 24'd19 || r24 !== 24'd20)
      $display("FAIL unsigned_704_36: got q=%0d r=%0d want q=19 r=20", q24, r24);
    else passed++;
    total++;
    if (dz24 !== 1'b0 || ov24 !== 1'b0)
      $display("FAIL unsigned_flags: got dz=%b ov=%b want 0 0", dz24, ov24);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (rdy24 !== 1'b0 || bsy24 !== 1'b0 || q24 !== 24'd19)
      $display("FAIL unsigned_after: got rdy=%b bsy=%b q=%0d want 0 0 19", rdy24, bsy24, q24);
    else passed++;
  endtask

  task automatic test_signed();
    int lat; bit bok;
    launch24(1'b1, 24'hFFFD40, 24'h000024, lat, bok);
    total++;
    if (q24 !== 24'hFFFFED || r24 !== 24'hFFFFEC || lat !== 24)
      $display("FAIL signed_neg_pos: got q=%h r=%h lat=%0d want q=ffffed r=ffffec lat=24", q24, r24, lat);
    else passed++;
    launch24(1'b1, 24'd704, 24'hFFFFDC, lat, bok);
    total++;
    if (q24 !== 24'hFFFFED || r24 !== 24'h000014)
      $display("FAIL signed_pos_neg: got q=%h r=%h want q=ffffed r=000014", q24, r24);
    else passed++;
    launch24(1'b1, 24'hFFFD40, 24'hFFFFDC, lat, bok);
    total++;
    if (q24 !== 24'h000013 || r24 !== 24'hFFFFEC || ov24 !== 1'b0)
      $display("FAIL signed_neg_neg: got q=%h r=%h ov=%b want q=000013 r=ffffec ov=0", q24, r24, ov24);
    else passed++;
  endtask

  task automatic test_div_zero();
    int lat; bit bok;
    launch24(1'b0, 24'd1234, 24'd0, lat, bok);
    total++;
    if (lat !== 0 || !bok) $display("FAIL divzero_latency: got lat=%0d busy_ok=%b want 0 1", lat, bok); else passed++;
    total++;
    if (q24 !== 24'hFFFFFF || r24 !== 24'd1234)
      $display("FAIL divzero_result: got q=%h r=%0d want q=ffffff r=1234", q24, r24);
    else passed++;
    total++;
    if (dz24 !== 1'b1 || ov24 !== 1'b0)
      $display("FAIL divzero_flags: got dz=%b ov=%b want 1 0", dz24, ov24);
    else passed++;
    launch24(1'b1, 24'hFFFFF6, 24'd0, lat, bok);
    total++;
    if (q24 !== 24'hFFFFFF || r24 !== 24'hFFFFF6 || dz24 !== 1'b1)
      $display("FAIL divzero_signed: got q=%h r=%h dz=%b want ffffff fffff6 1", q24, r24, dz24);
    else passed++;
  endtask

  task automatic test_overflow();
    int lat; bit bok;
    launch24(1'b1, 24'h800000, 24'hFFFFFF, lat, bok);
    total++;
    if (q24 !== 24'h800000 || r24 !== 24'd0 || lat !== 24)
      $display("FAIL overflow_result: got q=%h r=%h lat=%0d want 800000 000000 24", q24, r24, lat);
    else passed++;
    total++;
    if (ov24 !== 1'b1 || dz24 !== 1'b0)
      $display("FAIL overflow_flags: got ov=%b dz=%b want 1 0", ov24, dz24);
    else passed++;
    launch24(1'b0, 24'h800000, 24'hFFFFFF, lat, bok);
    total++;
    if (q24 !== 24'd0 || r24 !== 24'h800000 || ov24 !== 1'b0)
      $display("FAIL overflow_unsigned: got q=%h r=%h ov=%b want 000000 800000 0", q24, r24, ov24);
    else passed++;
  endtask

  task automatic test_annul();
    int lat; bit bok; bit seen;
    // Start and annul together in IDLE: start must be dropped.
    @(posedge clk); #1;
    s24 = 1'b0; a24 = 24'd704; b24 = 24'd36; st24 = 1'b1; an24 = 1'b1;
    @(posedge clk); #1;
    st24 = 1'b0; an24 = 1'b0;
    total++;
    if (bsy24 !== 1'b0) $display("FAIL annul_idle_start: got busy=%b want 0", bsy24); else passed++;
    // Annul at step 10.
    @(posedge clk); #1;
    a24 = 24'd704; b24 = 24'd36; st24 = 1'b1;
    @(posedge clk); #1;
    st24 = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    an24 = 1'b1;
    total++;
    if (bsy24 !== 1'b1) $display("FAIL annul_pre_busy: got busy=%b want 1", bsy24); else passed++;
    @(posedge clk); #1;
    an24 = 1'b0;
    total++;
    if (bsy24 !== 1'b0) $display("FAIL annul_busy_drop: got busy=%b want 0", bsy24); else passed++;
    seen = rdy24;
    repeat (30) begin
      @(posedge clk); #1;
      if (rdy24) seen = 1'b1;
    end
    total++;
    if (seen) $display("FAIL annul_no_ready: got ready pulse want none"); else passed++;
    total++;
    if (q24 !== 24'd0 || r24 !== 24'h800000 || ov24 !== 1'b0 || dz24 !== 1'b0)
      $display("FAIL annul_hold: got q=%h r=%h ov=%b dz=%b want 000000 800000 0 0", q24, r24, ov24, dz24);
    else passed++;
    launch24(1'b0, 24'd100, 24'd7, lat, bok);
    total++;
    if (q24 !== 24'd14 || r24 !== 24'd2 || lat !== 24)
      $display("FAIL annul_next_op: got q=%0d r=%0d lat=%0d want 14 2 24", q24, r24, lat);
    else passed++;
  endtask

  task automatic test_w8_start_held();
    int lat; bit bok;
    @(posedge clk); #1;
    s8 = 1'b0; a8 = 8'd200; b8 = 8'd7; st8 = 1'b1;
    @(posedge clk); #1;
    lat = 0; bok = bsy8;
    while (!rdy8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (!bsy8) bok = 1'b0;
    end
    st8 = 1'b0;
    total++;
    if (lat !== 8 || !bok) $display("FAIL w8_latency: got lat=%0d busy_ok=%b want 8 1", lat, bok); else passed++;
    total++;
    if (q8 !== 8'd28 || r8 !== 8'd4 || dz8 !== 1'b0 || ov8 !== 1'b0)
      $display("FAIL w8_200_7: got q=%0d r=%0d dz=%b ov=%b want 28 4 0 0", q8, r8, dz8, ov8);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (bsy8 !== 1'b0 || rdy8 !== 1'b0)
      $display("FAIL w8_back_idle: got busy=%b rdy=%b want 0 0", bsy8, rdy8);
    else passed++;
  endtask

  task automatic test_w8_reset_mid();
    bit seen;
    @(posedge clk); #1;
    s8 = 1'b1; a8 = 8'h80; b8 = 8'hFF; st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst8 = 1'b1;
    @(posedge clk); #1;
    rst8 = 1'b0;
    total++;
    if ({q8, r8, rdy8, bsy8, dz8, ov8} !== 20'd0)
      $display("FAIL w8_reset_mid: got q=%h r=%h rdy=%b bsy=%b dz=%b ov=%b want all 0", q8, r8, rdy8, bsy8, dz8, ov8);
    else passed++;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (rdy8 || bsy8) seen = 1'b1;
    end
    total++;
    if (seen) $display("FAIL w8_reset_quiet: got activity after reset want none"); else passed++;
  endtask

  initial begin
    rst = 1'b1; rst8 = 1'b1;
    s24 = 1'b0; st24 = 1'b0; an24 = 1'b0; a24 = '0; b24 = '0;
    s8 = 1'b0; st8 = 1'b0; an8 = 1'b0; a8 = '0; b8 = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_annul();
    test_w8_start_held();
    test_w8_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
